// File: rtl/wca_rbus_pkg.sv
// Shared rbus definitions: control-word bit layout, bus widths, master FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wca_rbus_pkg;

  localparam int RBUS_CTRL_W = 12;
  localparam int RBUS_DATA_W = 8;
  localparam int RBUS_ADDR_W = 8;

  // rbusCtrl bit positions; address occupies [ADDR_LSB +: RBUS_ADDR_W]
  localparam int CLKBUS   = 0;
  localparam int STROBE   = 1;
  localparam int WREN     = 2;
  localparam int RDEN     = 3;
  localparam int ADDR_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_FALL,
    ST_RISE,
    ST_RELEASE
  } rbus_state_e;

  // Assemble a control word from its fields using the bit positions above.
  function automatic logic [RBUS_CTRL_W-1:0] rbus_ctrl(
    input logic [RBUS_ADDR_W-1:0] addr,
    input logic                   rden,
    input logic                   wren,
    input logic                   strobe,
    input logic                   clkbus
  );
    logic [RBUS_CTRL_W-1:0] c;
    c = '0;
    c[ADDR_LSB +: RBUS_ADDR_W] = addr;
    c[RDEN]   = rden;
    c[WREN]   = wren;
    c[STROBE] = strobe;
    c[CLKBUS] = clkbus;
    return c;
  endfunction

endpackage

// File: rtl/wca_rbus_phase_timer.sv
// Loadable down-counter; phase_last is high while the count sits at zero.
// Latency: load takes effect on the next clock; phase_last is registered-count decode.
// Backpressure: none; load has priority over counting, count saturates at zero.
module wca_rbus_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise step down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last = (cnt_q == '0);

endmodule

// File: rtl/wca_rbus_master.sv
// rbus host stage: turns one byte read/write command into a SETUP/STROBE/FALL/RISE/RELEASE bus cycle.
// Latency: acceptance to done pulse is 5*PHASE_CYCLES+1 clocks; all outputs registered.
// Backpressure: cmd_ready is high only in IDLE; one command in flight at a time.
module wca_rbus_master
  import wca_rbus_pkg::*;
#(
  parameter int   PHASE_CYCLES = 2,
  parameter logic IDLE_CLKBUS  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [RBUS_ADDR_W-1:0] cmd_addr,
  input  logic [RBUS_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [RBUS_DATA_W-1:0] rsp_data,
  output logic                   done,
  output logic [RBUS_CTRL_W-1:0] rbusCtrl,
  inout  wire  [RBUS_DATA_W-1:0] rbusData
);

  localparam int               CNT_W      = $clog2(PHASE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);

  rbus_state_e            state_q, state_d;
  logic [RBUS_ADDR_W-1:0] addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [RBUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [RBUS_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                   oe_q, oe_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [RBUS_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   accept;
  logic                   timer_load;
  logic                   phase_last;

  assign accept     = cmd_valid && ready_q;
  assign timer_load = (state_d != state_q);

  wca_rbus_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_val   (PHASE_LOAD),
    .phase_last (phase_last)
  );

  // Sequencing, command capture, read sampling and next-cycle bus outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          addr_d  = cmd_addr;
          wr_d    = cmd_write;
          wdata_d = cmd_wdata;
        end
      end
      ST_SETUP:  if (phase_last) state_d = ST_STROBE;
      ST_STROBE: if (phase_last) state_d = ST_FALL;
      ST_FALL: begin
        if (phase_last) begin
          state_d = ST_RISE;
          // The addressed register has been driving since SETUP; take it at the end of the low phase.
          if (!wr_q) rsp_data_d = rbusData;
        end
      end
      ST_RISE:   if (phase_last) state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (phase_last) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          rsp_valid_d = !wr_q;
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state register.
    ctrl_d = rbus_ctrl('0, 1'b0, 1'b0, 1'b0, IDLE_CLKBUS);
    oe_d   = 1'b0;
    unique case (state_d)
      ST_SETUP: begin
        ctrl_d = rbus_ctrl(addr_d, !wr_d, wr_d, 1'b0, 1'b1);
        oe_d   = wr_d;
      end
      ST_STROBE: begin
        ctrl_d = rbus_ctrl(addr_d, !wr_d, wr_d, 1'b1, 1'b1);
        oe_d   = wr_d;
      end
      ST_FALL: begin
        ctrl_d = rbus_ctrl(addr_d, !wr_d, wr_d, 1'b1, 1'b0);
        oe_d   = wr_d;
      end
      ST_RISE: begin
        ctrl_d = rbus_ctrl(addr_d, !wr_d, wr_d, 1'b0, 1'b1);
        oe_d   = wr_d;
      end
      ST_RELEASE: begin
        ctrl_d = rbus_ctrl(addr_d, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      default: ;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset parks the bus idle with clkbus at its idle level.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ctrl_q      <= rbus_ctrl('0, 1'b0, 1'b0, 1'b0, IDLE_CLKBUS);
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Only writes ever enable the driver, so a read never contends with the addressed register.
  assign rbusData  = oe_q ? wdata_q : {RBUS_DATA_W{1'bz}};
  assign rbusCtrl  = ctrl_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_wca_rbus_master.sv
// Bench for wca_rbus_master at PHASE_CYCLES 2, 1 and 4 with an attached byte-register model.
// Latency: n/a.
// Backpressure: commands are held until cmd_ready is seen.
module tb_wca_rbus_master;
  import wca_rbus_pkg::*;

  localparam int PH [3] = '{2, 1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, cmd_valid, cmd_write;
  logic [7:0] cmd_addr [3];
  logic [7:0] cmd_wdata [3];
  wire  [2:0] cmd_ready, rsp_valid, done;
  wire  [7:0] rsp_data [3];
  wire  [11:0] ctrl [3];
  wire  [7:0] bus0, bus1, bus2;
  logic [7:0] bus_v [3];

  wca_rbus_master #(.PHASE_CYCLES(2), .IDLE_CLKBUS(1'b1)) u_p2 (
    .clock(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .done(done[0]),
    .rbusCtrl(ctrl[0]), .rbusData(bus0));
  wca_rbus_master #(.PHASE_CYCLES(1), .IDLE_CLKBUS(1'b1)) u_p1 (
    .clock(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .done(done[1]),
    .rbusCtrl(ctrl[1]), .rbusData(bus1));
  wca_rbus_master #(.PHASE_CYCLES(4), .IDLE_CLKBUS(1'b1)) u_p4 (
    .clock(clk), .reset(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_write(cmd_write[2]), .cmd_addr(cmd_addr[2]), .cmd_wdata(cmd_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .done(done[2]),
    .rbusCtrl(ctrl[2]), .rbusData(bus2));

  // Byte-register model: 0x34 is a fixed 0xC3 location, others capture on clkbus fall.
  logic [7:0] dev_mem [3][256];
  logic [2:0] drv_en;
  logic [7:0] drv_val [3];

  always_comb begin
    bus_v[0] = bus0;
    bus_v[1] = bus1;
    bus_v[2] = bus2;
  end

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      drv_en[g]  = ctrl[g][RDEN];
      drv_val[g] = (ctrl[g][ADDR_LSB +: 8] == 8'h34) ? 8'hC3 : dev_mem[g][ctrl[g][ADDR_LSB +: 8]];
    end
  end

  assign bus0 = drv_en[0] ? drv_val[0] : 8'hzz;
  assign bus1 = drv_en[1] ? drv_val[1] : 8'hzz;
  assign bus2 = drv_en[2] ? drv_val[2] : 8'hzz;

  int fall_tot [3]   = '{0, 0, 0};
  int low_tot [3]    = '{0, 0, 0};
  int strobe_tot [3] = '{0, 0, 0};
  int en_tot [3]     = '{0, 0, 0};
  int ovl_tot [3]    = '{0, 0, 0};
  int done_tot [3]   = '{0, 0, 0};
  int rsp_tot [3]    = '{0, 0, 0};
  logic [2:0] clk_prev = 3'b111;

  // Bus monitor: running totals of edges, phase widths and pulses; register capture.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      clk_prev[g] <= ctrl[g][CLKBUS];
      if (clk_prev[g] && !ctrl[g][CLKBUS]) begin
        fall_tot[g] <= fall_tot[g] + 1;
        if (ctrl[g][WREN] && ctrl[g][ADDR_LSB +: 8] != 8'h34)
          dev_mem[g][ctrl[g][ADDR_LSB +: 8]] <= bus_v[g];
      end
      if (!ctrl[g][CLKBUS]) low_tot[g] <= low_tot[g] + 1;
      if (ctrl[g][STROBE]) strobe_tot[g] <= strobe_tot[g] + 1;
      if (ctrl[g][RDEN] || ctrl[g][WREN]) en_tot[g] <= en_tot[g] + 1;
      if (ctrl[g][RDEN] && ctrl[g][WREN]) ovl_tot[g] <= ovl_tot[g] + 1;
      if (done[g]) done_tot[g] <= done_tot[g] + 1;
      if (rsp_valid[g]) rsp_tot[g] <= rsp_tot[g] + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int s_fall [3], s_low [3], s_strobe [3], s_en [3], s_done [3], s_rsp [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] released(input logic [7:0] v);
    return 32'((v === 8'hzz) || (v === 8'h00));
  endfunction

  task automatic snap(input int g);
    s_fall[g]   = fall_tot[g];
    s_low[g]    = low_tot[g];
    s_strobe[g] = strobe_tot[g];
    s_en[g]     = en_tot[g];
    s_done[g]   = done_tot[g];
    s_rsp[g]    = rsp_tot[g];
  endtask

  task automatic deltas(input int g, input string tag, input int ef, input int el,
                        input int es, input int ee, input int ed, input int er);
    chk({tag, "_falls"},  fall_tot[g] - s_fall[g], ef);
    chk({tag, "_low"},    low_tot[g] - s_low[g], el);
    chk({tag, "_strobe"}, strobe_tot[g] - s_strobe[g], es);
    chk({tag, "_enable"}, en_tot[g] - s_en[g], ee);
    chk({tag, "_dones"},  done_tot[g] - s_done[g], ed);
    chk({tag, "_rsps"},   rsp_tot[g] - s_rsp[g], er);
  endtask

  // One complete command: latency is counted in clocks from the accepting edge to the edge that consumes done.
  task automatic do_cmd(input int g, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output int busy, output logic [7:0] rd, output logic rv);
    int w;
    int n;
    @(negedge clk);
    cmd_valid[g] = 1'b1; cmd_write[g] = wr; cmd_addr[g] = a; cmd_wdata[g] = d;
    w = 0;
    while (!cmd_ready[g] && w < 100) begin @(negedge clk); w++; end
    chk($sformatf("p%0d_accept_timeout", PH[g]), 32'(w >= 100), 0);
    @(posedge clk);
    n = 0; busy = 0;
    while (n < 200) begin
      @(negedge clk);
      cmd_valid[g] = 1'b0;
      if (done[g]) break;
      if (!cmd_ready[g]) busy++;
      @(posedge clk);
      n++;
    end
    lat = n + 1;
    rd  = rsp_data[g];
    rv  = rsp_valid[g];
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("p%0d_done_one_cycle", PH[g]), 32'(done[g]), 0);
  endtask

  initial begin
    int lat, busy, n, bad, k;
    logic [7:0] rd, a, d;
    logic rv, wr;
    bit known [256];
    logic [7:0] ref_mem [256];

    rst = 3'b111; cmd_valid = '0; cmd_write = '0;
    for (int g = 0; g < 3; g++) begin cmd_addr[g] = '0; cmd_wdata[g] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("p%0d_rst_ready", PH[g]), 32'(cmd_ready[g]), 0);
      chk($sformatf("p%0d_rst_done", PH[g]), 32'(done[g]), 0);
      chk($sformatf("p%0d_rst_rsp_valid", PH[g]), 32'(rsp_valid[g]), 0);
      chk($sformatf("p%0d_rst_rsp_data", PH[g]), 32'(rsp_data[g]), 0);
      chk($sformatf("p%0d_rst_ctrl", PH[g]), 32'(ctrl[g]), 32'h001);
      chk($sformatf("p%0d_rst_bus_z", PH[g]), released(bus_v[g]), 1);
    end
    rst = 3'b000;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("p%0d_ready_after_rst", PH[g]), 32'(cmd_ready[g]), 1);

    // Write 0x5A to 0x12.
    snap(0);
    do_cmd(0, 1'b1, 8'h12, 8'h5A, lat, busy, rd, rv);
    chk("wr_latency", lat, 11);
    chk("wr_busy_cycles", busy, 10);
    deltas(0, "wr", 1, 2, 4, 8, 1, 0);
    chk("wr_reg_value", 32'(dev_mem[0][8'h12]), 32'h5A);
    chk("wr_bus_z_after", released(bus0), 1);

    // Read 0x34 (fixed 0xC3).
    snap(0);
    do_cmd(0, 1'b0, 8'h34, 8'h99, lat, busy, rd, rv);
    chk("rd_latency", lat, 11);
    chk("rd_data", 32'(rd), 32'hC3);
    chk("rd_rsp_valid", 32'(rv), 1);
    deltas(0, "rd", 1, 2, 4, 8, 1, 1);

    // Back-to-back: write 0x01@0x10 then read 0x10 with cmd_valid held high.
    snap(0);
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 8'h10; cmd_wdata[0] = 8'h01;
    chk("b2b_ready_first", 32'(cmd_ready[0]), 1);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    cmd_write[0] = 1'b0; cmd_addr[0] = 8'h10; cmd_wdata[0] = 8'hEE;
    while (!done[0] && n < 200) begin @(posedge clk); n++; @(negedge clk); end
    chk("b2b_first_latency", n + 1, 11);
    chk("b2b_ready_with_done", 32'(cmd_ready[0]), 1);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    chk("b2b_ready_drops", 32'(cmd_ready[0]), 0);
    while (!done[0] && n < 200) begin @(posedge clk); n++; @(negedge clk); end
    chk("b2b_second_latency", n + 1, 11);
    chk("b2b_rd_data", 32'(rsp_data[0]), 32'h01);
    chk("b2b_rsp_valid", 32'(rsp_valid[0]), 1);
    @(negedge clk);
    deltas(0, "b2b", 2, 4, 8, 16, 2, 1);

    // Reset during the FALL phase of a write 0xFF@0x20.
    snap(0);
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 8'h20; cmd_wdata[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    n = 0;
    while (ctrl[0][CLKBUS] && n < 50) begin @(negedge clk); n++; end
    chk("rstfall_reached_fall", 32'(n >= 50), 0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rstfall_ctrl", 32'(ctrl[0]), 32'h001);
    chk("rstfall_bus_z", released(bus0), 1);
    chk("rstfall_ready", 32'(cmd_ready[0]), 0);
    rst[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstfall_one_fall", fall_tot[0] - s_fall[0], 1);
    chk("rstfall_no_done", done_tot[0] - s_done[0], 0);
    chk("rstfall_reg_value", 32'(dev_mem[0][8'h20]), 32'hFF);
    chk("rstfall_ready_back", 32'(cmd_ready[0]), 1);

    // Idle for 100 cycles.
    snap(0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ctrl[0] !== 12'h001 || cmd_ready[0] !== 1'b1 || done[0] !== 1'b0 || rsp_valid[0] !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    deltas(0, "idle", 0, 0, 0, 0, 0, 0);

    // Phase widths and latency at PHASE_CYCLES 1 and 4.
    for (int g = 1; g < 3; g++) begin
      snap(g);
      do_cmd(g, 1'b1, 8'h55, 8'hA7, lat, busy, rd, rv);
      chk($sformatf("p%0d_wr_latency", PH[g]), lat, 5 * PH[g] + 1);
      chk($sformatf("p%0d_wr_busy", PH[g]), busy, 5 * PH[g]);
      deltas(g, $sformatf("p%0d_wr", PH[g]), 1, PH[g], 2 * PH[g], 4 * PH[g], 1, 0);
      snap(g);
      do_cmd(g, 1'b0, 8'h55, 8'h00, lat, busy, rd, rv);
      chk($sformatf("p%0d_rd_latency", PH[g]), lat, 5 * PH[g] + 1);
      chk($sformatf("p%0d_rd_data", PH[g]), 32'(rd), 32'hA7);
      deltas(g, $sformatf("p%0d_rd", PH[g]), 1, PH[g], 2 * PH[g], 4 * PH[g], 1, 1);
    end

    // Random traffic against a plain address->byte reference memory.
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 256; i++) known[i] = 1'b0;
      for (int t = 0; t < 12; t++) begin
        k  = int'($urandom_range(0, 7));
        a  = (k == 7) ? 8'hFF : 8'(k * 37);
        wr = ($urandom_range(0, 1) == 1) || !known[a];
        d  = 8'($urandom);
        do_cmd(g, wr, a, d, lat, busy, rd, rv);
        chk($sformatf("p%0d_rand%0d_latency", PH[g], t), lat, 5 * PH[g] + 1);
        if (wr) begin
          ref_mem[a] = d;
          known[a]   = 1'b1;
        end else begin
          chk($sformatf("p%0d_rand%0d_rd_data", PH[g], t), 32'(rd), 32'(ref_mem[a]));
          chk($sformatf("p%0d_rand%0d_rsp_valid", PH[g], t), 32'(rv), 1);
        end
      end
      chk($sformatf("p%0d_enable_overlap", PH[g]), ovl_tot[g], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
